// File: rtl/keypad_pkg.sv
// Shared types and constants for the keypad front end (scanner and debounce).
package keypad_pkg;

    typedef enum logic {SCAN, PRESSED} scan_state_t;

    localparam int NUM_ROWS   = 4;
    localparam int NUM_COLS   = 4;
    localparam int KEY_CODE_W = 8;

    // True only when exactly one bit of v is set.
    function automatic logic onehot_count1(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

endpackage

// File: rtl/keypad_scanner_sync2.sv
// Two-flop synchronizer for asynchronous multi-bit level inputs.
module sync2 #(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks the columns, latches a single pressed key
// as a one-hot {row, col} code and holds button_on until the key is released.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 4,
    parameter int RELEASE_CYCLES = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_ROWS-1:0]   rows,
    output logic [NUM_COLS-1:0]   cols,
    output logic [KEY_CODE_W-1:0] keypad_val,
    output logic                  button_on
);

    localparam logic [7:0] SETTLE_LAST  = 8'(SETTLE_CYCLES - 1);
    localparam logic [7:0] RELEASE_LAST = 8'(RELEASE_CYCLES - 1);

    logic [NUM_ROWS-1:0]   rows_sync;
    logic [NUM_ROWS-1:0]   rows_a;
    scan_state_t           state_q, state_d;
    logic [1:0]            col_idx_q, col_idx_d;
    logic [7:0]            settle_cnt_q, settle_cnt_d;
    logic [7:0]            release_cnt_q, release_cnt_d;
    logic [NUM_COLS-1:0]   cols_q, cols_d;
    logic [KEY_CODE_W-1:0] keypad_val_q, keypad_val_d;
    logic                  button_on_q, button_on_d;
    logic [NUM_COLS-1:0]   col_oh;
    logic                  row_hit;

    sync2 #(
        .WIDTH     (NUM_ROWS),
        .RESET_VAL (4'b1111)
    ) u_row_sync (
        .clk (clk),
        .rst (reset),
        .d_i (rows),
        .q_o (rows_sync)
    );

    assign rows_a  = ~rows_sync;
    assign col_oh  = 4'b0001 << col_idx_q;
    // Only the latched row matters while pressed; the upper code nibble holds it.
    assign row_hit = |(rows_a & keypad_val_q[7:4]);

    always_comb begin
        state_d       = state_q;
        col_idx_d     = col_idx_q;
        settle_cnt_d  = settle_cnt_q;
        release_cnt_d = release_cnt_q;
        keypad_val_d  = keypad_val_q;
        button_on_d   = button_on_q;

        case (state_q)
            SCAN: begin
                if (settle_cnt_q < SETTLE_LAST) begin
                    settle_cnt_d = settle_cnt_q + 8'd1;
                end else if (onehot_count1(rows_a)) begin
                    state_d       = PRESSED;
                    keypad_val_d  = {rows_a, col_oh};
                    button_on_d   = 1'b1;
                    release_cnt_d = 8'd0;
                    settle_cnt_d  = 8'd0;
                end else begin
                    // No key or a ghost/multi-key read: move on to the next column.
                    col_idx_d    = col_idx_q + 2'd1;
                    settle_cnt_d = 8'd0;
                end
            end
            PRESSED: begin
                if (row_hit) begin
                    release_cnt_d = 8'd0;
                end else if (release_cnt_q == RELEASE_LAST) begin
                    state_d       = SCAN;
                    button_on_d   = 1'b0;
                    col_idx_d     = 2'd0;
                    settle_cnt_d  = 8'd0;
                    release_cnt_d = 8'd0;
                end else begin
                    release_cnt_d = release_cnt_q + 8'd1;
                end
            end
            default: state_d = SCAN;
        endcase

        cols_d = ~(4'b0001 << col_idx_d);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= SCAN;
            col_idx_q     <= 2'd0;
            settle_cnt_q  <= 8'd0;
            release_cnt_q <= 8'd0;
            cols_q        <= 4'b1110;
            keypad_val_q  <= '0;
            button_on_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            col_idx_q     <= col_idx_d;
            settle_cnt_q  <= settle_cnt_d;
            release_cnt_q <= release_cnt_d;
            cols_q        <= cols_d;
            keypad_val_q  <= keypad_val_d;
            button_on_q   <= button_on_d;
        end
    end

    assign cols       = cols_q;
    assign keypad_val = keypad_val_q;
    assign button_on  = button_on_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural 4x4 key matrix model.
module tb_keypad_scanner;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] rows;
    logic [3:0] cols;
    logic [7:0] keypad_val;
    logic       button_on;

    // keys[r][c] = 1 means key (row r, column c) is held down.
    logic [3:0][3:0] keys = '0;

    int checks = 0;
    int errors = 0;

    keypad_scanner #(
        .SETTLE_CYCLES  (4),
        .RELEASE_CYCLES (3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rows       (rows),
        .cols       (cols),
        .keypad_val (keypad_val),
        .button_on  (button_on)
    );

    always #5 clk = ~clk;

    always_comb begin
        rows = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            if (|(keys[r] & ~cols)) rows[r] = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_btn(input string tag, input logic lvl, input int budget);
        int n;
        n = 0;
        while (button_on !== lvl && n < budget) begin
            tick();
            n++;
        end
        check(tag, {31'd0, button_on}, {31'd0, lvl});
    endtask

    initial begin
        int hits;
        int changes;
        logic [3:0] prev;

        // 1: reset values, mid-cycle async reset, column stepping
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (6) tick();
        check("pre_reset_cols", {28'd0, cols}, 32'h0000000d);
        #3;
        reset = 1'b1;
        #1;
        check("rst_cols", {28'd0, cols}, 32'h0000000e);
        check("rst_val", {24'd0, keypad_val}, 32'h00000000);
        check("rst_btn", {31'd0, button_on}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            tick();
            case (k)
                3:  check("step3_cols", {28'd0, cols}, 32'h0000000e);
                4:  check("step4_cols", {28'd0, cols}, 32'h0000000d);
                8:  check("step8_cols", {28'd0, cols}, 32'h0000000b);
                12: check("step12_cols", {28'd0, cols}, 32'h00000007);
                16: check("step16_cols", {28'd0, cols}, 32'h0000000e);
                default: ;
            endcase
        end

        // 2: single key (row2, col1)
        keys[2][1] = 1'b1;
        wait_btn("t2_press", 1'b1, 17);
        check("t2_val", {24'd0, keypad_val}, 32'h00000042);
        check("t2_cols", {28'd0, cols}, 32'h0000000d);
        repeat (5) tick();
        check("t2_cols_frozen", {28'd0, cols}, 32'h0000000d);

        // 3: short release glitch is ignored, full release takes exactly 5 cycles
        keys[2][1] = 1'b0;
        repeat (2) tick();
        keys[2][1] = 1'b1;
        hits = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (button_on !== 1'b1) hits++;
        end
        check("t3_glitch_drops", hits, 0);
        keys[2][1] = 1'b0;
        repeat (4) tick();
        check("t3_rel_cycle4", {31'd0, button_on}, 32'd1);
        tick();
        check("t3_rel_cycle5", {31'd0, button_on}, 32'd0);
        check("t3_val_held", {24'd0, keypad_val}, 32'h00000042);
        check("t3_cols_restart", {28'd0, cols}, 32'h0000000e);

        // 4: two keys in column 3 are rejected, then one survives
        keys[0][3] = 1'b1;
        keys[3][3] = 1'b1;
        hits = 0;
        changes = 0;
        prev = cols;
        for (int k = 0; k < 32; k++) begin
            tick();
            if (button_on !== 1'b0) hits++;
            if (cols != prev) changes++;
            prev = cols;
        end
        check("t4_ghost_btn", hits, 0);
        check("t4_ghost_scan", {31'd0, (changes >= 6)}, 32'd1);
        keys[3][3] = 1'b0;
        wait_btn("t4_single", 1'b1, 20);
        check("t4_val", {24'd0, keypad_val}, 32'h00000018);
        check("t4_cols", {28'd0, cols}, 32'h00000007);

        // 5: other keys ignored while a key is latched
        keys[0][3] = 1'b0;
        wait_btn("t5_release", 1'b0, 10);
        keys[1][0] = 1'b1;
        wait_btn("t5_press", 1'b1, 20);
        check("t5_val", {24'd0, keypad_val}, 32'h00000021);
        keys[1][2] = 1'b1;
        repeat (20) tick();
        check("t5_val_kept", {24'd0, keypad_val}, 32'h00000021);
        check("t5_btn_kept", {31'd0, button_on}, 32'd1);
        check("t5_cols_kept", {28'd0, cols}, 32'h0000000e);

        // 6: reset while pressed, key re-latched after a fresh scan
        keys[1][2] = 1'b0;
        #3;
        reset = 1'b1;
        #1;
        check("t6_rst_btn", {31'd0, button_on}, 32'd0);
        check("t6_rst_val", {24'd0, keypad_val}, 32'h00000000);
        check("t6_rst_cols", {28'd0, cols}, 32'h0000000e);
        @(negedge clk);
        reset = 1'b0;
        wait_btn("t6_relatch", 1'b1, 17);
        check("t6_val", {24'd0, keypad_val}, 32'h00000021);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Drives the 4x4 matrix keypad columns one at a time and reads back the rows.
- Detects a single pressed key and emits its 8-bit one-hot row/column code plus a press-valid flag.
- Sits directly upstream of the debounce stage, which consumes keypad_val and button_on.
- Also synchronizes the asynchronous row inputs and rejects multi-key (ghost) reads.

Parameters:
SETTLE_CYCLES, 4, clk cycles each column is driven before rows are sampled; must be >= 3 to cover the 2-flop synchronizer; legal range 3..255.
RELEASE_CYCLES, 3, consecutive cycles the latched row must read inactive before a release is accepted; legal range 1..255.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
rows  input  4  raw keypad row lines, active-low (pulled up), asynchronous to clk
cols  output  4  column drive, active-low; exactly one bit low at all times
keypad_val  output  8  {row_onehot[3:0], col_onehot[3:0]}, active-high; bit 0 = column 0, bit 4 = row 0
button_on  output  1  high while a validly latched key is held

Behaviour:
- Row synchronizer: two flops on rows; internal rows_a = ~rows_sync (active-high). All decisions use rows_a only.
- Reset (async, active-high) values: state=SCAN, col_idx=0, settle_cnt=0, release_cnt=0, cols=4'b1110, keypad_val=8'h00, button_on=0, both synchronizer stages=4'b1111.
- Column drive: cols = ~(4'b0001 << col_idx), registered. A column change appears on cols in the same cycle the state update commits.
- SCAN state:
  - settle_cnt increments each cycle while it is below SETTLE_CYCLES-1.
  - At settle_cnt==SETTLE_CYCLES-1 (the sample cycle), rows_a is evaluated:
  - Exactly one bit set: latch row_oh=rows_a and col_oh=1<<col_idx. Next cycle: keypad_val={row_oh,col_oh}, button_on=1, state=PRESSED, release_cnt=0, col_idx held.
  - Zero bits set, or two or more bits set (ghost/multi-key): col_idx advances by 1, wrapping 3->0; settle_cnt=0; outputs unchanged.
- PRESSED state:
  - cols stays on the latched column.
  - If the latched row bit in rows_a is 0, release_cnt increments. If it is 1, release_cnt clears.
  - When release_cnt reaches RELEASE_CYCLES-1 with the row still 0: next cycle state=SCAN, button_on=0, col_idx=0, settle_cnt=0. keypad_val holds the last code; it is not cleared.
  - Other keys are ignored while in PRESSED: other rows on the same column, and any key on other columns (those columns are not driven).
- Simultaneous events:
  - A release glitch shorter than RELEASE_CYCLES does not drop button_on.
  - A key pressed on the sample cycle alongside another key in the same column counts as multi-key and is rejected.
- Latency: a row must be stable from at least 2 cycles before the sample cycle. Worst-case press-to-button_on is 4*SETTLE_CYCLES+1 cycles after the row goes low. Release-to-button_on-low is RELEASE_CYCLES+2 cycles (2 synchronizer cycles plus RELEASE_CYCLES).
- Reset mid-operation (SCAN or PRESSED): immediately returns all state to reset values; a held key is re-detected by a fresh scan from column 0.
- Width rules: settle_cnt and release_cnt are 8 bits; col_idx is 2 bits with natural wrap.

Decomposition:
- Package keypad_pkg holds:
  - typedef enum logic {SCAN, PRESSED} scan_state_t
  - localparam NUM_ROWS=4, NUM_COLS=4, KEY_CODE_W=8
  - function onehot_count1(logic [3:0]) returning 1 for exactly one bit set
- The debounce stage imports KEY_CODE_W from the same package.
- One sub-module: sync2, a parameterized-width two-flop synchronizer with async active-high reset and a reset value parameter (4'b1111 here).

Test Plan (SETTLE_CYCLES=4, RELEASE_CYCLES=3; the bench models the matrix as rows[r]=0 when key(r,c) is pressed and cols[c]==0):
1. Reset asserted mid-cycle with no keys pressed -> cols=4'b1110, keypad_val=8'h00, button_on=0 immediately. After release, cols steps 1110->1101->1011->0111->1110 every 4 cycles.
2. Press key(row2,col1) and hold -> within 17 cycles, keypad_val=8'b0100_0010, button_on=1, cols frozen at 4'b1101.
3. With the scenario-2 key held, release it for 2 cycles then re-press -> button_on stays 1. A full release -> button_on=0 exactly 5 cycles after the row returns high, keypad_val stays 8'b0100_0010, scanning restarts at cols=4'b1110.
4. Press key(row0,col3) and key(row3,col3) together -> button_on never asserts and cols keeps cycling. Release row3 only -> keypad_val=8'b0001_1000, button_on=1.
5. With key(row1,col0) latched, press key(row1,col2) -> no change to keypad_val (8'b0010_0001) or button_on.
6. Assert reset while in PRESSED with the key still held -> button_on=0, keypad_val=8'h00 asynchronously. After reset drops, the same code is re-latched within 17 cycles.
